// File: rtl/gray_codec_if.sv
// Stream interface for gray_codec: input beat channel and result channel.
interface gray_codec_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic [WIDTH-1:0] out_gray;

    // Producer/consumer side of the codec
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_bin, out_gray
    );

    // Codec side
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_bin, out_gray
    );
endinterface

// File: rtl/gray_codec.sv
// Two-stage pipelined Gray/binary codec with an integrated up/down Gray counter.
// S1 holds {mode, operand}; S2 holds the finished {bin, gray} pair.
module gray_codec #(
    parameter int unsigned WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    gray_codec_if.slave bus_io
);
    typedef enum logic [1:0] {
        ModeB2G  = 2'b00,
        ModeG2B  = 2'b01,
        ModeUp   = 2'b10,
        ModeDown = 2'b11
    } mode_e;

    logic             s1_valid_q, s1_valid_d;
    mode_e            s1_mode_q, s1_mode_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_bin_q, s2_bin_d;
    logic [WIDTH-1:0] s2_gray_q, s2_gray_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    logic             s1_adv, s2_adv, in_xfer;
    logic [WIDTH-1:0] conv_bin, conv_gray;

    // Prefix XOR from the MSB down turns a Gray word back into binary.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign s2_adv  = !s2_valid_q || bus_io.out_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign in_xfer = bus_io.in_valid && bus_io.in_ready;

    assign bus_io.in_ready  = s1_adv && !rst;
    assign bus_io.out_valid = s2_valid_q;
    assign bus_io.out_bin   = s2_bin_q;
    assign bus_io.out_gray  = s2_gray_q;

    // S1 load and counter update; counter beats carry the new count as operand
    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        if (s1_adv) begin
            s1_valid_d = in_xfer;
        end
        if (in_xfer) begin
            s1_mode_d = mode_e'(bus_io.in_mode);
            unique case (mode_e'(bus_io.in_mode))
                ModeUp: begin
                    cnt_d     = cnt_q + WIDTH'(1);
                    s1_data_d = cnt_d;
                end
                ModeDown: begin
                    cnt_d     = cnt_q - WIDTH'(1);
                    s1_data_d = cnt_d;
                end
                default: begin
                    s1_data_d = bus_io.in_data;
                end
            endcase
        end
    end

    // Conversion between S1 and S2; only Gray operands need the prefix XOR
    always_comb begin
        conv_bin  = s1_data_q;
        conv_gray = s1_data_q ^ (s1_data_q >> 1);
        if (s1_mode_q == ModeG2B) begin
            conv_bin  = gray2bin(s1_data_q);
            conv_gray = s1_data_q;
        end
    end

    // S2 load; data holds whenever the consumer stalls
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_bin_d   = s2_bin_q;
        s2_gray_d  = s2_gray_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_bin_d  = conv_bin;
                s2_gray_d = conv_gray;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= ModeB2G;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_bin_q   <= '0;
            s2_gray_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_bin_q   <= s2_bin_d;
            s2_gray_q  <= s2_gray_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec: directed cases plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_gray_codec;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_codec_if #(.WIDTH(W)) bus ();
    gray_codec #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    gray_codec_if #(.WIDTH(8)) bus8 ();
    gray_codec #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus_io(bus8));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] g;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] mcnt;
    logic         prev_stall = 1'b0;
    logic         prev_rst = 1'b0;
    beat_t        prev_out;

    logic [W-1:0] col_b[32];
    logic [W-1:0] col_g[32];
    int           col_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gray of a binary value: each bit flags a change between neighbouring bits.
    function automatic logic [W-1:0] m_gray(input logic [W-1:0] b);
        return b ^ (b / 2);
    endfunction

    // Binary of a Gray value found by searching for the preimage.
    function automatic logic [W-1:0] m_bin(input logic [W-1:0] g);
        for (int v = 0; v < (1 << W); v++) begin
            if (m_gray(W'(v)) == g) return W'(v);
        end
        return '0;
    endfunction

    // Per-cycle scoreboard; inputs are stable from negedge until the next posedge
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", bus.in_ready, 0);
            q.delete();
            mcnt       = '0;
            prev_rst   = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("post_rst_out_valid", bus.out_valid, 0);
                chk("post_rst_out_bin", bus.out_bin, 0);
                chk("post_rst_out_gray", bus.out_gray, 0);
                chk("post_rst_in_ready", bus.in_ready, 1);
            end
            chk("in_ready_model", bus.in_ready, (q.size() < 2) || bus.out_ready);
            if (prev_stall) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_bin", bus.out_bin, prev_out.b);
                chk("stall_hold_gray", bus.out_gray, prev_out.g);
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    chk("out_bin_model", bus.out_bin, q[0].b);
                    chk("out_gray_model", bus.out_gray, q[0].g);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                case (bus.in_mode)
                    2'b00: q.push_back('{b: bus.in_data, g: m_gray(bus.in_data)});
                    2'b01: q.push_back('{b: m_bin(bus.in_data), g: bus.in_data});
                    2'b10: begin
                        mcnt = mcnt + 1'b1;
                        q.push_back('{b: mcnt, g: m_gray(mcnt)});
                    end
                    default: begin
                        mcnt = mcnt - 1'b1;
                        q.push_back('{b: mcnt, g: m_gray(mcnt)});
                    end
                endcase
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = '{b: bus.out_bin, g: bus.out_gray};
            prev_rst   = 1'b0;
        end
    end

    task automatic do_reset(input int n);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1
    task automatic send(input logic [1:0] m, input logic [W-1:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, report value and negedges waited; returns at posedge+1
    task automatic wait_out(output logic [W-1:0] b, output logic [W-1:0] g, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        if (!bus.out_valid) chk("wait_out_timeout", 1, 0);
        b = bus.out_bin;
        g = bus.out_gray;
        @(posedge clk);
        #1;
    endtask

    // Record accepted output beats; ends on a negedge
    task automatic collect(input int n);
        int cyc = 0;
        col_n = 0;
        while (col_n < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid && bus.out_ready) begin
                col_b[col_n] = bus.out_bin;
                col_g[col_n] = bus.out_gray;
                col_n++;
            end
        end
        chk("collect_count", col_n, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rb, rg;
        int           lat;
        logic [W-1:0] up_gray[16];
        logic [W-1:0] prev_g;
        up_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_mode   = 2'b00;
        bus8.in_data   = '0;
        bus8.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Mode 00 and mode 01 with latency
        send(2'b00, 4'b1011);
        wait_out(rb, rg, lat);
        chk("b2g_latency", lat, 2);
        chk("b2g_bin", rb, 4'b1011);
        chk("b2g_gray", rg, 4'b1110);
        send(2'b01, 4'b1110);
        wait_out(rb, rg, lat);
        chk("g2b_bin", rb, 4'b1011);
        chk("g2b_gray", rg, 4'b1110);

        // Wide build, Gray all-ones
        bus8.in_valid = 1'b1;
        bus8.in_mode  = 2'b01;
        bus8.in_data  = 8'hFF;
        @(negedge clk);
        chk("w8_in_ready", bus8.in_ready, 1);
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        for (int i = 0; i < 10 && !bus8.out_valid; i++) @(negedge clk);
        chk("w8_out_valid", bus8.out_valid, 1);
        chk("w8_bin", bus8.out_bin, 8'hAA);
        chk("w8_gray", bus8.out_gray, 8'hFF);
        @(posedge clk);
        #1;

        // Count up 16 beats back-to-back
        do_reset(1);
        fork
            begin
                for (int i = 0; i < 16; i++) send(2'b10, 4'h0);
            end
            collect(16);
        join
        @(posedge clk);
        #1;
        prev_g = 4'h0;
        for (int i = 0; i < 16; i++) begin
            chk("up_gray_seq", col_g[i], up_gray[i]);
            chk("up_bin_seq", col_b[i], (i + 1) % 16);
            chk("up_one_bit", $countones(col_g[i] ^ prev_g), 1);
            prev_g = col_g[i];
        end

        // Count down, conversion in between, then up: cnt is held
        do_reset(1);
        fork
            begin
                send(2'b11, 4'h0);
                send(2'b00, 4'b0101);
                send(2'b10, 4'h0);
            end
            collect(3);
        join
        @(posedge clk);
        #1;
        chk("down_bin", col_b[0], 4'b1111);
        chk("down_gray", col_g[0], 4'b1000);
        chk("mid_b2g_gray", col_g[1], 4'b0111);
        chk("held_cnt_bin", col_b[2], 4'b0000);

        // Backpressure: out_ready low for cycles 3-6
        do_reset(1);
        fork
            begin
                for (int i = 1; i <= 5; i++) send(2'b00, W'(i));
            end
            begin
                bus.out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", bus.in_ready, 0);
                chk("bp_out_valid", bus.out_valid, 1);
            end
            collect(5);
        join
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bin", col_b[i], i + 1);
            chk("bp_gray", col_g[i], m_gray(W'(i + 1)));
        end

        // Reset with both stages full and cnt=7
        do_reset(1);
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 7; i++) send(2'b10, 4'h0);
            end
            collect(7);
        join
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(2'b00, 4'h3);
        send(2'b00, 4'h9);
        @(negedge clk);
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_bin", bus.out_bin, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        fork
            send(2'b10, 4'h0);
            collect(1);
        join
        @(posedge clk);
        #1;
        chk("after_rst_count", col_b[0], 4'b0001);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_mode   = 2'($urandom_range(0, 3));
            bus.in_data   = W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            rst           = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
